// File: rtl/multicycle_maindec_if.sv
// Control bus between the multicycle main decoder and the datapath.
// The decoder sits on the slave modport. The datapath or bench sits on the
// master modport.
// The master drives the opcode from the instruction register and the
// memory-ready handshake.
// The slave returns the datapath control strobes, the mux selects, the
// illegal-opcode flag and the debug state code.
interface multicycle_maindec_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       memwrite;
    logic       lord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        output op, mem_ready,
        input  memwrite, lord, irwrite, pcwrite, branch, branch_ne, regdst,
               memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop,
               illegal_op, state_o
    );

    modport slave (
        input  op, mem_ready,
        output memwrite, lord, irwrite, pcwrite, branch, branch_ne, regdst,
               memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop,
               illegal_op, state_o
    );
endinterface

// File: rtl/multicycle_maindec.sv
// Moore main control FSM for the multicycle MIPS datapath.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; every control output is forced to 0
//          while it is high
//   bus    slave side of multicycle_maindec_if
//          inputs:  op, mem_ready
//          outputs: control strobes, mux selects, illegal_op, state_o
// Controls are decoded from the state register. The only input-dependent
// terms are the mem_ready qualification of the FETCH strobes and the reset
// gating.
// Parameters:
//   BNE_EN   1 = opcode 000101 is BNE, 0 = it is illegal
//   TRAP_EN  1 = an illegal opcode parks the FSM in TRAP until reset
//            0 = illegal_op is flagged in DECODE only, then back to FETCH
module multicycle_maindec #(
    parameter logic BNE_EN  = 1'b1,
    parameter logic TRAP_EN = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_maindec_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12,
        S_TRAP    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam state_t ILL_NEXT = (TRAP_EN == 1'b1) ? S_TRAP : S_FETCH;

    state_t     state_r;
    logic       op_illegal_s;
    logic       memwrite_s, lord_s, irwrite_s, pcwrite_s, branch_s;
    logic       branch_ne_s, regdst_s, memtoreg_s, regwrite_s, alusrca_s;
    logic       illegal_op_s;
    logic [1:0] alusrcb_s, pcsrc_s, aluop_s;

    // Opcode legality check, honouring the BNE enable.
    always_comb begin
        op_illegal_s = 1'b1;
        case (bus.op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_illegal_s = 1'b0;
            OP_BNE:  op_illegal_s = (BNE_EN == 1'b1) ? 1'b0 : 1'b1;
            default: op_illegal_s = 1'b1;
        endcase
    end

    // State register and next-state logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:   state_r <= bus.mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if (op_illegal_s) begin
                        state_r <= ILL_NEXT;
                    end else begin
                        case (bus.op)
                            OP_RTYPE:     state_r <= S_RTYPEEX;
                            OP_LW, OP_SW: state_r <= S_MEMADR;
                            OP_BEQ:       state_r <= S_BEQEX;
                            OP_ADDI:      state_r <= S_ADDIEX;
                            OP_J:         state_r <= S_JEX;
                            OP_BNE:       state_r <= S_BNEEX;
                            default:      state_r <= ILL_NEXT;
                        endcase
                    end
                end
                // The IR is not written here, so op still selects LW or SW.
                S_MEMADR:  state_r <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   state_r <= bus.mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:   state_r <= S_FETCH;
                S_MEMWR:   state_r <= bus.mem_ready ? S_FETCH : S_MEMWR;
                S_RTYPEEX: state_r <= S_RTYPEWB;
                S_RTYPEWB: state_r <= S_FETCH;
                S_BEQEX:   state_r <= S_FETCH;
                S_BNEEX:   state_r <= S_FETCH;
                S_ADDIEX:  state_r <= S_ADDIWB;
                S_ADDIWB:  state_r <= S_FETCH;
                S_JEX:     state_r <= S_FETCH;
                S_TRAP:    state_r <= S_TRAP;
                default:   state_r <= S_FETCH;
            endcase
        end
    end

    // Control decode from the state register. Reset forces every control
    // output low, so no write strobe can fire during reset.
    always_comb begin
        memwrite_s   = 1'b0;
        lord_s       = 1'b0;
        irwrite_s    = 1'b0;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        branch_ne_s  = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        regwrite_s   = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        pcsrc_s      = 2'b00;
        aluop_s      = 2'b00;
        illegal_op_s = 1'b0;
        if (!reset) begin
            case (state_r)
                S_FETCH: begin
                    alusrcb_s = 2'b01;
                    irwrite_s = bus.mem_ready;
                    pcwrite_s = bus.mem_ready;
                end
                S_DECODE: begin
                    alusrcb_s    = 2'b11;
                    illegal_op_s = (TRAP_EN == 1'b0) ? op_illegal_s : 1'b0;
                end
                S_MEMADR: begin
                    alusrca_s = 1'b1;
                    alusrcb_s = 2'b10;
                end
                S_MEMRD:  lord_s = 1'b1;
                S_MEMWB: begin
                    memtoreg_s = 1'b1;
                    regwrite_s = 1'b1;
                end
                S_MEMWR: begin
                    lord_s     = 1'b1;
                    memwrite_s = 1'b1;
                end
                S_RTYPEEX: begin
                    alusrca_s = 1'b1;
                    aluop_s   = 2'b10;
                end
                S_RTYPEWB: begin
                    regdst_s   = 1'b1;
                    regwrite_s = 1'b1;
                end
                S_BEQEX: begin
                    alusrca_s = 1'b1;
                    aluop_s   = 2'b01;
                    pcsrc_s   = 2'b01;
                    branch_s  = 1'b1;
                end
                S_BNEEX: begin
                    alusrca_s   = 1'b1;
                    aluop_s     = 2'b01;
                    pcsrc_s     = 2'b01;
                    branch_ne_s = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca_s = 1'b1;
                    alusrcb_s = 2'b10;
                end
                S_ADDIWB: regwrite_s = 1'b1;
                S_JEX: begin
                    pcsrc_s   = 2'b10;
                    pcwrite_s = 1'b1;
                end
                S_TRAP:   illegal_op_s = 1'b1;
                default:  illegal_op_s = 1'b0;
            endcase
        end else begin
            illegal_op_s = 1'b0;
        end
    end

    assign bus.memwrite   = memwrite_s;
    assign bus.lord       = lord_s;
    assign bus.irwrite    = irwrite_s;
    assign bus.pcwrite    = pcwrite_s;
    assign bus.branch     = branch_s;
    assign bus.branch_ne  = branch_ne_s;
    assign bus.regdst     = regdst_s;
    assign bus.memtoreg   = memtoreg_s;
    assign bus.regwrite   = regwrite_s;
    assign bus.alusrca    = alusrca_s;
    assign bus.alusrcb    = alusrcb_s;
    assign bus.pcsrc      = pcsrc_s;
    assign bus.aluop      = aluop_s;
    assign bus.illegal_op = illegal_op_s;
    assign bus.state_o    = state_r;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Scoreboard bench for multicycle_maindec.
// Three instances share one stimulus stream:
//   a: BNE_EN=1, TRAP_EN=1
//   b: BNE_EN=1, TRAP_EN=0
//   c: BNE_EN=0, TRAP_EN=1
// Each driven cycle pushes the expected state of every instance. The monitor
// pops an entry each cycle and checks state_o plus the packed control vector.
module tb_multicycle_maindec;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ILL  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b000000;
    logic       mem_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         ea;
        int         eb;
        int         ec;
        logic       r;
        logic [5:0] o;
        logic       m;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;

    multicycle_maindec_if bus_a ();
    multicycle_maindec_if bus_b ();
    multicycle_maindec_if bus_c ();

    assign bus_a.op = op;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.op = op;
    assign bus_b.mem_ready = mem_ready;
    assign bus_c.op = op;
    assign bus_c.mem_ready = mem_ready;

    multicycle_maindec #(.BNE_EN(1'b1), .TRAP_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    multicycle_maindec #(.BNE_EN(1'b1), .TRAP_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    multicycle_maindec #(.BNE_EN(1'b0), .TRAP_EN(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    always #5 clk = ~clk;

    // Packed controls, MSB first:
    // memwrite lord irwrite pcwrite branch branch_ne regdst memtoreg
    // regwrite alusrca alusrcb pcsrc aluop illegal_op
    wire [16:0] ctrl_a = {bus_a.memwrite, bus_a.lord, bus_a.irwrite, bus_a.pcwrite,
                          bus_a.branch, bus_a.branch_ne, bus_a.regdst, bus_a.memtoreg,
                          bus_a.regwrite, bus_a.alusrca, bus_a.alusrcb, bus_a.pcsrc,
                          bus_a.aluop, bus_a.illegal_op};
    wire [16:0] ctrl_b = {bus_b.memwrite, bus_b.lord, bus_b.irwrite, bus_b.pcwrite,
                          bus_b.branch, bus_b.branch_ne, bus_b.regdst, bus_b.memtoreg,
                          bus_b.regwrite, bus_b.alusrca, bus_b.alusrcb, bus_b.pcsrc,
                          bus_b.aluop, bus_b.illegal_op};
    wire [16:0] ctrl_c = {bus_c.memwrite, bus_c.lord, bus_c.irwrite, bus_c.pcwrite,
                          bus_c.branch, bus_c.branch_ne, bus_c.regdst, bus_c.memtoreg,
                          bus_c.regwrite, bus_c.alusrca, bus_c.alusrcb, bus_c.pcsrc,
                          bus_c.aluop, bus_c.illegal_op};

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected control vector for a given state, written from the control table.
    function automatic int exp_ctrl(input int st, input logic m, input logic r,
                                    input logic [5:0] o, input logic bne_en,
                                    input logic trap_en);
        logic       mw, ld, irw, pcw, br, brn, rd, m2r, rw, sa, ill;
        logic [1:0] sb, ps, ao;
        logic       bad;
        {mw, ld, irw, pcw, br, brn, rd, m2r, rw, sa, ill} = 11'd0;
        sb = 2'b00;
        ps = 2'b00;
        ao = 2'b00;
        bad = !(o == RT || o == LW || o == SW || o == BEQ || o == ADDI || o == JMP ||
                (o == BNE && bne_en));
        if (!r) begin
            case (st)
                0:  begin sb = 2'b01; irw = m; pcw = m; end
                1:  begin sb = 2'b11; ill = bad && !trap_en; end
                2:  begin sa = 1'b1; sb = 2'b10; end
                3:  ld = 1'b1;
                4:  begin m2r = 1'b1; rw = 1'b1; end
                5:  begin ld = 1'b1; mw = 1'b1; end
                6:  begin sa = 1'b1; ao = 2'b10; end
                7:  begin rd = 1'b1; rw = 1'b1; end
                8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
                9:  begin sa = 1'b1; sb = 2'b10; end
                10: rw = 1'b1;
                11: begin ps = 2'b10; pcw = 1'b1; end
                12: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; brn = 1'b1; end
                15: ill = 1'b1;
                default: ill = 1'b0;
            endcase
        end
        return int'({mw, ld, irw, pcw, br, brn, rd, m2r, rw, sa, sb, ps, ao, ill});
    endfunction

    // Drive one cycle of stimulus and queue the expected current states.
    task automatic cyc(input logic r, input logic [5:0] o, input logic m,
                       input int ea, input int eb, input int ec);
        @(negedge clk);
        #1;
        reset = r;
        op = o;
        mem_ready = m;
        sb_q.push_back('{ea, eb, ec, r, o, m});
    endtask

    // Monitor: compare mid-low-phase, after the inputs settle and before the next rising edge.
    always @(negedge clk) begin
        #3;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("state_a", int'(bus_a.state_o), mon_e.ea);
            check("ctrl_a", int'(ctrl_a), exp_ctrl(mon_e.ea, mon_e.m, mon_e.r, mon_e.o, 1'b1, 1'b1));
            check("state_b", int'(bus_b.state_o), mon_e.eb);
            check("ctrl_b", int'(ctrl_b), exp_ctrl(mon_e.eb, mon_e.m, mon_e.r, mon_e.o, 1'b1, 1'b0));
            check("state_c", int'(bus_c.state_o), mon_e.ec);
            check("ctrl_c", int'(ctrl_c), exp_ctrl(mon_e.ec, mon_e.m, mon_e.r, mon_e.o, 1'b0, 1'b1));
        end
    end

    initial begin
        // Reset held for two cycles, then RTYPE: 0,1,6,7.
        cyc(1'b1, RT, 1'b1, 0, 0, 0);
        cyc(1'b1, RT, 1'b1, 0, 0, 0);
        cyc(1'b0, RT, 1'b1, 0, 0, 0);
        cyc(1'b0, RT, 1'b1, 1, 1, 1);
        cyc(1'b0, RT, 1'b1, 6, 6, 6);
        cyc(1'b0, RT, 1'b1, 7, 7, 7);
        // LW with a two-cycle fetch stall and a three-cycle MEMRD stall.
        cyc(1'b0, LW, 1'b0, 0, 0, 0);
        cyc(1'b0, LW, 1'b0, 0, 0, 0);
        cyc(1'b0, LW, 1'b1, 0, 0, 0);
        cyc(1'b0, LW, 1'b1, 1, 1, 1);
        cyc(1'b0, LW, 1'b1, 2, 2, 2);
        for (int i = 0; i < 3; i++) cyc(1'b0, LW, 1'b0, 3, 3, 3);
        cyc(1'b0, LW, 1'b1, 3, 3, 3);
        cyc(1'b0, LW, 1'b1, 4, 4, 4);
        // SW with a one-cycle MEMWR stall.
        cyc(1'b0, SW, 1'b1, 0, 0, 0);
        cyc(1'b0, SW, 1'b1, 1, 1, 1);
        cyc(1'b0, SW, 1'b1, 2, 2, 2);
        cyc(1'b0, SW, 1'b0, 5, 5, 5);
        cyc(1'b0, SW, 1'b1, 5, 5, 5);
        // BEQ, J, ADDI.
        cyc(1'b0, BEQ, 1'b1, 0, 0, 0);
        cyc(1'b0, BEQ, 1'b1, 1, 1, 1);
        cyc(1'b0, BEQ, 1'b1, 8, 8, 8);
        cyc(1'b0, JMP, 1'b1, 0, 0, 0);
        cyc(1'b0, JMP, 1'b1, 1, 1, 1);
        cyc(1'b0, JMP, 1'b1, 11, 11, 11);
        cyc(1'b0, ADDI, 1'b1, 0, 0, 0);
        cyc(1'b0, ADDI, 1'b1, 1, 1, 1);
        cyc(1'b0, ADDI, 1'b1, 9, 9, 9);
        cyc(1'b0, ADDI, 1'b1, 10, 10, 10);
        // BNE: a and b take BNEEX; c, without BNE, traps.
        cyc(1'b0, BNE, 1'b1, 0, 0, 0);
        cyc(1'b0, BNE, 1'b1, 1, 1, 1);
        cyc(1'b0, BNE, 1'b1, 12, 12, 15);
        cyc(1'b1, BNE, 1'b1, 0, 0, 15);
        // Illegal opcode: a and c stick in TRAP; b flags in DECODE and refetches.
        cyc(1'b0, ILL, 1'b1, 0, 0, 0);
        cyc(1'b0, ILL, 1'b1, 1, 1, 1);
        for (int i = 0; i < 12; i++) cyc(1'b0, ILL, 1'b1, 15, (i % 2 == 0) ? 0 : 1, 15);
        cyc(1'b1, ILL, 1'b1, 15, 0, 15);
        // Reset in the middle of a MEMRD stall.
        cyc(1'b0, LW, 1'b1, 0, 0, 0);
        cyc(1'b0, LW, 1'b1, 1, 1, 1);
        cyc(1'b0, LW, 1'b1, 2, 2, 2);
        cyc(1'b0, LW, 1'b0, 3, 3, 3);
        cyc(1'b0, LW, 1'b0, 3, 3, 3);
        cyc(1'b1, LW, 1'b0, 3, 3, 3);
        cyc(1'b0, LW, 1'b0, 0, 0, 0);
        cyc(1'b0, LW, 1'b0, 0, 0, 0);
        // Let the monitor drain the last entry.
        @(negedge clk);
        @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_maindec.md
Name: multicycle_maindec

Overview:
Moore-style main control FSM for the multicycle MIPS datapath. It is the successor to the single-cycle main decoder and supports the same opcode set (RTYPE, LW, SW, BEQ, ADDI, J), plus an optional BNE and an illegal-opcode trap. A mem_ready handshake stalls instruction fetch and data access for variable-latency memory. It sits between the instruction register's op field and the multicycle datapath; ALU function decode remains in the separate aludec.

Parameters:
BNE_EN, 1, 1 = decode opcode 6'b000101 as BNE; 0 = treat it as illegal.
TRAP_EN, 1, 1 = illegal opcode enters sticky TRAP state; 0 = flag for one cycle and resume FETCH.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  opcode from instruction register
mem_ready  in  1  memory access completes this cycle
memwrite  out  1  data memory write strobe
lord  out  1  address mux: 0 = PC, 1 = ALUOut
irwrite  out  1  instruction register load
pcwrite  out  1  unconditional PC load
branch  out  1  PC load if zero
branch_ne  out  1  PC load if not zero
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = data register, 0 = ALUOut
regwrite  out  1  register file write
alusrca  out  1  0 = PC, 1 = A
alusrcb  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
aluop  out  2  00 = add, 01 = sub, 10 = funct
illegal_op  out  1  illegal opcode indication
state_o  out  4  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. At a rising edge with reset=1, state becomes FETCH.
- Output gating: while reset=1, every output is forced to 0 except state_o, which shows the registered state.
- Outputs: all outputs are decoded from the state register. Any output not listed for a state is 0. The only Mealy terms are the mem_ready qualifications noted below.
- State encoding (state_o): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12, TRAP=15. Codes 13 and 14 are unreachable and go to FETCH.
- FETCH: alusrcb=01; irwrite=mem_ready; pcwrite=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alusrcb=11. Next state by op:
  - 000000 → RTYPEEX
  - 100011 or 101011 → MEMADR
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - 000101 → BNEEX if BNE_EN=1
  - anything else is illegal.
- Illegal opcode with TRAP_EN=1: go to TRAP.
- Illegal opcode with TRAP_EN=0: illegal_op=1 during this DECODE cycle only, then FETCH.
- MEMADR: alusrca=1, alusrcb=10. op=100011 → MEMRD; otherwise → MEMWR. op is stable because the IR is not written.
- MEMRD: lord=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: memtoreg=1, regwrite=1 → FETCH.
- MEMWR: lord=1, memwrite=1, held through the stall. Go to FETCH when mem_ready=1.
- RTYPEEX: alusrca=1, aluop=10 → RTYPEWB.
- RTYPEWB: regdst=1, regwrite=1 → FETCH.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1 → FETCH.
- BNEEX: as BEQEX, but branch_ne=1 instead of branch → FETCH.
- ADDIEX: alusrca=1, alusrcb=10 → ADDIWB.
- ADDIWB: regwrite=1 → FETCH.
- JEX: pcsrc=10, pcwrite=1 → FETCH.
- TRAP: illegal_op=1; no write strobes asserted. Sticky; only reset exits.
- Latency with mem_ready tied to 1, counted in cycles from FETCH through the last state: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ/BNE 3, J 3. Each stall cycle adds exactly 1.
- Mutual exclusion: memwrite, regwrite and irwrite are never asserted together. At most one of pcwrite, branch and branch_ne is 1.
- Reset mid-instruction, in any state including a stall or TRAP: next edge gives FETCH; no partial write continues after that edge.

Test Plan:
- Reset held 2 cycles, then released with op=000000 and mem_ready=1 → state_o sequence 0,1,6,7,0. regwrite=1 and regdst=1 only in state 7. All outputs are 0 during reset.
- LW (op=100011) with mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMRD → sequence 0,0,0,1,2,3,3,3,3,4. irwrite pulses only on the mem_ready cycle. memtoreg=1 and regwrite=1 in state 4.
- SW (op=101011) with mem_ready=0 for 1 cycle in MEMWR → memwrite=1 and lord=1 for both MEMWR cycles, then FETCH. regwrite stays 0 throughout.
- BEQ 000100 → 0,1,8,0 with branch=1, aluop=01, pcsrc=01. J 000010 → 0,1,11,0 with pcwrite=1, pcsrc=10. BNE 000101 with BNE_EN=1 → state 12 with branch_ne=1.
- op=111111 with TRAP_EN=1 → state 15, illegal_op=1 held 10+ cycles, then reset → state 0. The same op with TRAP_EN=0 → illegal_op=1 for one cycle in DECODE, then state 0.
- BNE_EN=0 with op=000101 → handled as illegal. Reset asserted in MEMRD mid-stall → state 0 next cycle and memwrite/regwrite never asserted.
